fp_multiplier_pipelined: RTL

Parametrised, three-stage pipelined IEEE-754-style floating-point multiplier with valid/ready handshaking, selectable rounding mode and full exception flags. It is the next generation of the fixed 32-bit single-cycle multiplier in the arithmetic circuit library. It generalises format width, keeps one result per cycle under backpressure, and adds NaN/Inf/zero handling plus round-to-nearest-even. It sits between operand sources (testbench file readers or upstream datapath) and a result consumer.

---
 rtl/fp_mul_pkg.sv | 41 ++++
 rtl/fp_mul_round.sv | 52 +++++
 rtl/fp_multiplier_pipelined.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/fp_mul_pkg.sv
// Shared types and width helpers for the pipelined floating-point multiplier.
// Formats are sign|exponent|mantissa with flush-to-zero for subnormal operands.
package fp_mul_pkg;

    typedef struct packed {
        logic ov;
        logic uf;
        logic nx;
        logic nv;
    } fp_flags_t;

    typedef enum logic [1:0] {
        ZERO,
        NORM,
        INF,
        NAN
    } fp_class_t;

    localparam int MAX_W = 64;

    function automatic int word_w(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    function automatic int bias_of(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Ones from the mantissa MSB up through the whole exponent field, sign 0.
    function automatic logic [MAX_W-1:0] qnan_word(input int exp_w, input int man_w);
        return ((64'd1 << (exp_w + 1)) - 64'd1) << (man_w - 1);
    endfunction

    function automatic fp_class_t classify(input logic exp_zero, input logic exp_ones,
                                           input logic man_zero);
        if (exp_zero) return ZERO;
        if (exp_ones) return man_zero ? INF : NAN;
        return NORM;
    endfunction

endpackage

// File: rtl/fp_mul_round.sv
// Final stage of the multiplier: round the normalised significand, then detect
// overflow/underflow and pack the result word with its flags.
module fp_mul_round
    import fp_mul_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     sign,
    input  logic signed [EXP_W+1:0]  e_in,
    input  logic [MAN_W:0]           sig,
    input  logic                     guard,
    input  logic                     sticky,
    input  logic                     rm,
    output logic [EXP_W+MAN_W:0]     c,
    output fp_flags_t                flags
);
    localparam int EW = EXP_W + 2;
    localparam logic [EW-2:0] EXP_MAX = (EW-1)'((1 << EXP_W) - 1);

    logic                   inc;
    logic [MAN_W+1:0]       sum;
    logic signed [EW-1:0]   exp_r;
    logic [MAN_W-1:0]       frac;
    logic                   is_ov;
    logic                   is_uf;

    always_comb begin
        inc   = !rm && guard && (sticky || sig[0]);
        sum   = {1'b0, sig} + {{(MAN_W+1){1'b0}}, inc};
        // A carry out of the significand means 1.000..0 at the next exponent.
        exp_r = e_in + {{(EW-1){1'b0}}, sum[MAN_W+1]};
        frac  = sum[MAN_W+1] ? sum[MAN_W:1] : sum[MAN_W-1:0];
        is_ov = !exp_r[EW-1] && (exp_r[EW-2:0] >= EXP_MAX);
        is_uf = exp_r[EW-1] || (exp_r == '0);

        flags    = '0;
        flags.nx = guard || sticky;
        c        = {sign, exp_r[EXP_W-1:0], frac};
        if (is_ov) begin
            flags.ov = 1'b1;
            flags.nx = 1'b1;
            c = rm ? {sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}}
                   : {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (is_uf) begin
            flags.uf = 1'b1;
            flags.nx = 1'b1;
            c = {sign, {(EXP_W+MAN_W){1'b0}}};
        end
    end

endmodule

// File: rtl/fp_multiplier_pipelined.sv
// Three-stage floating-point multiplier: unpack/multiply, normalise, round/pack.
// One global enable stalls every stage while a presented result is not taken.
module fp_multiplier_pipelined
    import fp_mul_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [EXP_W+MAN_W:0]  a,
    input  logic [EXP_W+MAN_W:0]  b,
    input  logic                  rm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [EXP_W+MAN_W:0]  c,
    output logic                  ov,
    output logic                  uf,
    output logic                  nx,
    output logic                  nv
);
    localparam int W  = word_w(EXP_W, MAN_W);
    localparam int EW = EXP_W + 2;
    localparam int PW = 2 * MAN_W + 2;
    localparam logic [W-1:0]  QNAN = W'(qnan_word(EXP_W, MAN_W));
    localparam logic [EW-1:0] BIAS = EW'(bias_of(EXP_W));

    // Handshake: a transfer happens on a rising edge where valid && ready; a
    // source holds its data while ready is low, and so does this block's output.
    logic en;

    logic                 v1_q, v1_d, s1_sign_q, s1_sign_d, s1_rm_q, s1_rm_d;
    logic                 s1_spec_q, s1_spec_d;
    logic signed [EW-1:0] s1_exp_q, s1_exp_d;
    logic [PW-1:0]        s1_prod_q, s1_prod_d;
    logic [W-1:0]         s1_spec_c_q, s1_spec_c_d;
    fp_flags_t            s1_spec_f_q, s1_spec_f_d;

    logic                 v2_q, v2_d, s2_sign_q, s2_sign_d, s2_rm_q, s2_rm_d;
    logic                 s2_spec_q, s2_spec_d, s2_guard_q, s2_guard_d;
    logic                 s2_sticky_q, s2_sticky_d;
    logic signed [EW-1:0] s2_exp_q, s2_exp_d;
    logic [MAN_W:0]       s2_sig_q, s2_sig_d;
    logic [W-1:0]         s2_spec_c_q, s2_spec_c_d;
    fp_flags_t            s2_spec_f_q, s2_spec_f_d;

    logic                 out_valid_q, out_valid_d;
    logic [W-1:0]         c_q, c_d;
    fp_flags_t            flags_q, flags_d;

    fp_class_t            a_cls, b_cls;
    logic                 sign_in, zero_inf, a_snan, b_snan;
    logic                 sp_in;
    logic [W-1:0]         sp_c_in;
    fp_flags_t            sp_f_in;
    logic [W-1:0]         rnd_c;
    fp_flags_t            rnd_f;

    assign en        = !out_valid_q || out_ready;
    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign c         = c_q;
    assign ov        = flags_q.ov;
    assign uf        = flags_q.uf;
    assign nx        = flags_q.nx;
    assign nv        = flags_q.nv;

    always_comb begin
        a_cls    = classify(a[W-2:MAN_W] == '0, &a[W-2:MAN_W], a[MAN_W-1:0] == '0);
        b_cls    = classify(b[W-2:MAN_W] == '0, &b[W-2:MAN_W], b[MAN_W-1:0] == '0);
        sign_in  = a[W-1] ^ b[W-1];
        zero_inf = (a_cls == ZERO && b_cls == INF) || (a_cls == INF && b_cls == ZERO);
        a_snan   = (a_cls == NAN) && !a[MAN_W-1];
        b_snan   = (b_cls == NAN) && !b[MAN_W-1];
        sp_in    = 1'b1;
        sp_c_in  = '0;
        sp_f_in  = '0;
        if (a_cls == NAN || b_cls == NAN || zero_inf) begin
            sp_c_in    = QNAN;
            sp_f_in.nv = zero_inf || a_snan || b_snan;
        end else if (a_cls == INF || b_cls == INF) begin
            sp_c_in = {sign_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (a_cls == ZERO || b_cls == ZERO) begin
            sp_c_in = {sign_in, {(W-1){1'b0}}};
        end else begin
            sp_in = 1'b0;
        end
    end

    fp_mul_round #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
        .sign   (s2_sign_q),
        .e_in   (s2_exp_q),
        .sig    (s2_sig_q),
        .guard  (s2_guard_q),
        .sticky (s2_sticky_q),
        .rm     (s2_rm_q),
        .c      (rnd_c),
        .flags  (rnd_f)
    );

    always_comb begin
        v1_d = v1_q;  s1_sign_d = s1_sign_q;  s1_rm_d = s1_rm_q;  s1_spec_d = s1_spec_q;
        s1_exp_d = s1_exp_q;  s1_prod_d = s1_prod_q;
        s1_spec_c_d = s1_spec_c_q;  s1_spec_f_d = s1_spec_f_q;
        v2_d = v2_q;  s2_sign_d = s2_sign_q;  s2_rm_d = s2_rm_q;  s2_spec_d = s2_spec_q;
        s2_guard_d = s2_guard_q;  s2_sticky_d = s2_sticky_q;
        s2_exp_d = s2_exp_q;  s2_sig_d = s2_sig_q;
        s2_spec_c_d = s2_spec_c_q;  s2_spec_f_d = s2_spec_f_q;
        out_valid_d = out_valid_q;  c_d = c_q;  flags_d = flags_q;
        if (en) begin
            v1_d = in_valid;
            if (in_valid) begin
                s1_sign_d   = sign_in;
                s1_rm_d     = rm;
                s1_spec_d   = sp_in;
                s1_spec_c_d = sp_c_in;
                s1_spec_f_d = sp_f_in;
                s1_exp_d    = {2'b00, a[W-2:MAN_W]} + {2'b00, b[W-2:MAN_W]} - BIAS;
                s1_prod_d   = {{(MAN_W+1){1'b0}}, 1'b1, a[MAN_W-1:0]}
                            * {{(MAN_W+1){1'b0}}, 1'b1, b[MAN_W-1:0]};
            end
            v2_d = v1_q;
            if (v1_q) begin
                s2_sign_d   = s1_sign_q;
                s2_rm_d     = s1_rm_q;
                s2_spec_d   = s1_spec_q;
                s2_spec_c_d = s1_spec_c_q;
                s2_spec_f_d = s1_spec_f_q;
                // Product in [2,4): the bit shifted out joins the sticky OR.
                if (s1_prod_q[PW-1]) begin
                    s2_exp_d    = s1_exp_q + {{(EW-1){1'b0}}, 1'b1};
                    s2_sig_d    = s1_prod_q[PW-1:MAN_W+1];
                    s2_guard_d  = s1_prod_q[MAN_W];
                    s2_sticky_d = |s1_prod_q[MAN_W-1:0];
                end else begin
                    s2_exp_d    = s1_exp_q;
                    s2_sig_d    = s1_prod_q[PW-2:MAN_W];
                    s2_guard_d  = s1_prod_q[MAN_W-1];
                    s2_sticky_d = |s1_prod_q[MAN_W-2:0];
                end
            end
            out_valid_d = v2_q;
            if (v2_q) begin
                c_d     = s2_spec_q ? s2_spec_c_q : rnd_c;
                flags_d = s2_spec_q ? s2_spec_f_q : rnd_f;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q <= 1'b0;  s1_sign_q <= 1'b0;  s1_rm_q <= 1'b0;  s1_spec_q <= 1'b0;
            s1_exp_q <= '0;  s1_prod_q <= '0;  s1_spec_c_q <= '0;  s1_spec_f_q <= '0;
            v2_q <= 1'b0;  s2_sign_q <= 1'b0;  s2_rm_q <= 1'b0;  s2_spec_q <= 1'b0;
            s2_guard_q <= 1'b0;  s2_sticky_q <= 1'b0;  s2_exp_q <= '0;  s2_sig_q <= '0;
            s2_spec_c_q <= '0;  s2_spec_f_q <= '0;
            out_valid_q <= 1'b0;  c_q <= '0;  flags_q <= '0;
        end else begin
            v1_q <= v1_d;  s1_sign_q <= s1_sign_d;  s1_rm_q <= s1_rm_d;  s1_spec_q <= s1_spec_d;
            s1_exp_q <= s1_exp_d;  s1_prod_q <= s1_prod_d;
            s1_spec_c_q <= s1_spec_c_d;  s1_spec_f_q <= s1_spec_f_d;
            v2_q <= v2_d;  s2_sign_q <= s2_sign_d;  s2_rm_q <= s2_rm_d;  s2_spec_q <= s2_spec_d;
            s2_guard_q <= s2_guard_d;  s2_sticky_q <= s2_sticky_d;
            s2_exp_q <= s2_exp_d;  s2_sig_q <= s2_sig_d;
            s2_spec_c_q <= s2_spec_c_d;  s2_spec_f_q <= s2_spec_f_d;
            out_valid_q <= out_valid_d;  c_q <= c_d;  flags_q <= flags_d;
        end
    end

endmodule
